diff_sar_ctrl: RTL

//  Successive-approximation controller for the differential analog front end (tt_um_diff).

---
 rtl/diff_sar_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/diff_sar_ctrl.sv
// Successive-approximation controller for the differential front end: drives the
// track switch and DAC trial code, resolves one bit per SETTLE/COMPARE round.
//
// state   | meaning
// IDLE    | waiting for start; dac_code/result hold last values
// SAMPLE  | sample_o high, input tracked for SAMPLE_CYC cycles
// SETTLE  | DAC + comparator synchroniser settling, SETTLE_CYC+2 cycles
// COMPARE | read cmp_s, keep/clear current bit, set next trial bit
// DONE    | one-cycle done pulse, result updated
module diff_sar_ctrl #(
  parameter int WIDTH      = 8,
  parameter int SAMPLE_CYC = 4,
  parameter int SETTLE_CYC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             cmp_in,
  output logic             sample_o,
  output logic [WIDTH-1:0] dac_code,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CNT_MAX = (SAMPLE_CYC > SETTLE_CYC + 2) ? SAMPLE_CYC : SETTLE_CYC + 2;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = $clog2(WIDTH);

  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC + 1);
  localparam logic [BIT_W-1:0] MSB_IDX     = BIT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MSB_CODE    = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SAMPLE  = 3'd1;
  localparam logic [2:0] ST_SETTLE  = 3'd2;
  localparam logic [2:0] ST_COMPARE = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic             sample_q, sample_d;
  logic [WIDTH-1:0] dac_q, dac_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             sync1_q, cmp_s_q;

  logic [WIDTH-1:0] trial;
  logic [BIT_W-1:0] bit_dn;

  // Two-flop synchroniser for the asynchronous comparator decision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      cmp_s_q <= 1'b0;
    end else begin
      sync1_q <= cmp_in;
      cmp_s_q <= sync1_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    sample_d = sample_q;
    dac_d    = dac_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;

    trial = dac_q;
    if (!cmp_s_q) begin
      trial[bit_q] = 1'b0;
    end
    bit_dn = bit_q - BIT_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d  = ST_SAMPLE;
          busy_d   = 1'b1;
          sample_d = 1'b1;
          dac_d    = '0;
          cnt_d    = '0;
        end
      end

      ST_SAMPLE: begin
        if (abort) begin
          state_d  = ST_IDLE;
          sample_d = 1'b0;
          dac_d    = '0;
          busy_d   = 1'b0;
          cnt_d    = '0;
        end else if (cnt_q == SAMPLE_LAST) begin
          state_d  = ST_SETTLE;
          sample_d = 1'b0;
          dac_d    = MSB_CODE;
          bit_d    = MSB_IDX;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_SETTLE: begin
        if (abort) begin
          state_d  = ST_IDLE;
          sample_d = 1'b0;
          dac_d    = '0;
          busy_d   = 1'b0;
          cnt_d    = '0;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = ST_COMPARE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_COMPARE: begin
        if (abort) begin
          state_d  = ST_IDLE;
          sample_d = 1'b0;
          dac_d    = '0;
          busy_d   = 1'b0;
          cnt_d    = '0;
        end else if (bit_q == '0) begin
          // Result is taken from the final decided code so it is valid with done.
          state_d  = ST_DONE;
          dac_d    = trial;
          result_d = trial;
          done_d   = 1'b1;
        end else begin
          state_d       = ST_SETTLE;
          dac_d         = trial;
          dac_d[bit_dn] = 1'b1;
          bit_d         = bit_dn;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d  = ST_IDLE;
        sample_d = 1'b0;
        busy_d   = 1'b0;
        cnt_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      sample_q <= 1'b0;
      dac_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      sample_q <= sample_d;
      dac_q    <= dac_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign sample_o = sample_q;
  assign dac_code = dac_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;

endmodule
